rk_sram_arbiter: RTL and testbench

- Time-multiplexes the single external 8-bit async SRAM between three requesters: video DMA reads, the SD/tape loader (read/write) and the CPU (read/write).
- Generates SRAM address, data-bus drive and WE_N with fixed setup/pulse/hold timing at 50 MHz.
- Replaces the combinational vid_rd/CPU address mux in the top level.
- Video has absolute priority; loader and CPU share the remaining slots round-robin.

---
 rtl/rk_sram_arbiter_if.sv | 42 ++++
 rtl/rk_sram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_rk_sram_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rk_sram_arbiter_if.sv
// Requester ports and external SRAM pins of rk_sram_arbiter, grouped as one bus.
// The arbiter connects through the slave modport; requesters and the SRAM use master.
interface rk_sram_arbiter_if #(
  parameter int AW = 21
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_rdata;
  logic          vid_ack;
  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [7:0]    ldr_wdata;
  logic [7:0]    ldr_rdata;
  logic          ldr_ack;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_ack;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_dq_o;
  logic          sram_dq_oe;
  logic [7:0]    sram_dq_i;
  logic          sram_we_n;
  logic          busy;

  modport slave (
    input  vid_req, vid_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata,
           cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_dq_i,
    output vid_rdata, vid_ack, ldr_rdata, ldr_ack, cpu_rdata, cpu_ack,
           sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, busy
  );

  modport master (
    output vid_req, vid_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata,
           cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_dq_i,
    input  vid_rdata, vid_ack, ldr_rdata, ldr_ack, cpu_rdata, cpu_ack,
           sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, busy
  );
endinterface

// File: rtl/rk_sram_arbiter.sv
// Shares one 8-bit async SRAM between video DMA, loader and CPU with fixed
// setup/pulse/hold timing; video has absolute priority, loader/CPU alternate.
module rk_sram_arbiter #(
  parameter int AW          = 21,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk50,
  input  logic             reset,
  rk_sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_VID = 2'd0,
    OWN_LDR = 2'd1,
    OWN_CPU = 2'd2
  } owner_t;

  localparam logic       RR_CPU       = 1'b0;
  localparam logic       RR_LDR       = 1'b1;
  localparam logic [3:0] LP_WCNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t        r_state, w_next_state;
  owner_t        r_owner, w_gnt_owner;
  logic          r_we, r_rr;
  logic [3:0]    r_wcnt;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_dq_o;
  logic          r_we_n, r_oe;
  logic          r_vid_ack, r_ldr_ack, r_cpu_ack;
  logic [7:0]    r_vid_rdata, r_ldr_rdata, r_cpu_rdata;

  logic          w_grant, w_gnt_we, w_next_rr, w_eff_we;
  logic          w_enter_hold, w_next_oe, w_next_we_n;
  logic [AW-1:0] w_gnt_addr;
  logic [7:0]    w_gnt_wdata;

  // Grant selection, next state and next values of the registered SRAM strobes.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_gnt_owner  = OWN_CPU;
    w_gnt_we     = bus.cpu_we;
    w_gnt_addr   = bus.cpu_addr;
    w_gnt_wdata  = bus.cpu_wdata;
    w_next_rr    = r_rr;
    case (r_state)
      ST_IDLE: begin
        w_next_state = ST_SETUP;
        w_grant      = 1'b1;
        if (bus.vid_req) begin
          w_gnt_owner = OWN_VID;
          w_gnt_we    = 1'b0;
          w_gnt_addr  = bus.vid_addr;
          w_gnt_wdata = 8'h00;
        end else if (bus.ldr_req && (!bus.cpu_req || (r_rr == RR_LDR))) begin
          w_gnt_owner = OWN_LDR;
          w_gnt_we    = bus.ldr_we;
          w_gnt_addr  = bus.ldr_addr;
          w_gnt_wdata = bus.ldr_wdata;
          w_next_rr   = bus.cpu_req ? RR_CPU : r_rr;
        end else if (bus.cpu_req) begin
          w_next_rr   = bus.ldr_req ? RR_LDR : r_rr;
        end else begin
          w_next_state = ST_IDLE;
          w_grant      = 1'b0;
        end
      end
      ST_SETUP: begin
        w_next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (r_wcnt == LP_WCNT_LAST) begin
          w_next_state = ST_HOLD;
        end else begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_HOLD: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // The grant edge already needs the new direction, so take it from the winner.
    w_eff_we     = w_grant ? w_gnt_we : r_we;
    w_enter_hold = (r_state == ST_ACCESS) && (r_wcnt == LP_WCNT_LAST);
    w_next_oe    = (w_next_state != ST_IDLE) && w_eff_we;
    w_next_we_n  = !((w_next_state == ST_ACCESS) && w_eff_we);
  end

  // State register.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latched transaction, SRAM pins, acks and per-requester read data.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_CPU;
      r_we        <= 1'b0;
      r_rr        <= RR_CPU;
      r_wcnt      <= 4'd0;
      r_addr      <= '0;
      r_dq_o      <= 8'h00;
      r_we_n      <= 1'b1;
      r_oe        <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_ldr_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_vid_rdata <= 8'h00;
      r_ldr_rdata <= 8'h00;
      r_cpu_rdata <= 8'h00;
    end else begin
      r_rr      <= w_next_rr;
      r_we_n    <= w_next_we_n;
      r_oe      <= w_next_oe;
      r_vid_ack <= w_enter_hold && (r_owner == OWN_VID);
      r_ldr_ack <= w_enter_hold && (r_owner == OWN_LDR);
      r_cpu_ack <= w_enter_hold && (r_owner == OWN_CPU);
      if (w_grant) begin
        r_owner <= w_gnt_owner;
        r_we    <= w_gnt_we;
        r_addr  <= w_gnt_addr;
        r_dq_o  <= w_gnt_wdata;
      end
      if (r_state == ST_ACCESS) begin
        r_wcnt <= r_wcnt + 4'd1;
      end else begin
        r_wcnt <= 4'd0;
      end
      if (w_enter_hold && !r_we) begin
        case (r_owner)
          OWN_VID: r_vid_rdata <= bus.sram_dq_i;
          OWN_LDR: r_ldr_rdata <= bus.sram_dq_i;
          OWN_CPU: r_cpu_rdata <= bus.sram_dq_i;
          default: r_cpu_rdata <= r_cpu_rdata;
        endcase
      end
    end
  end

  assign bus.sram_addr  = r_addr;
  assign bus.sram_dq_o  = r_dq_o;
  assign bus.sram_dq_oe = r_oe;
  assign bus.sram_we_n  = r_we_n;
  assign bus.vid_ack    = r_vid_ack;
  assign bus.ldr_ack    = r_ldr_ack;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.vid_rdata  = r_vid_rdata;
  assign bus.ldr_rdata  = r_ldr_rdata;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_rk_sram_arbiter.sv
// Scoreboard bench for rk_sram_arbiter: behavioural async SRAM, ack/rdata/WE_N
// monitor, and directed scenarios on a WAIT_CYCLES=2 and a WAIT_CYCLES=1 instance.
`timescale 1ns/1ps
module tb_rk_sram_arbiter;
  localparam int AW = 21;
  localparam int W  = 2;
  localparam logic [1:0] ID_VID = 2'd0;
  localparam logic [1:0] ID_LDR = 2'd1;
  localparam logic [1:0] ID_CPU = 2'd2;

  typedef struct {
    logic [1:0] who;
    logic       is_rd;
    logic [7:0] data;
  } exp_t;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  logic [7:0] mem [int];

  rk_sram_arbiter_if #(.AW(AW)) bus ();
  rk_sram_arbiter_if #(.AW(AW)) bus1 ();

  rk_sram_arbiter #(.AW(AW), .WAIT_CYCLES(W)) dut (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bus)
  );

  rk_sram_arbiter #(.AW(AW), .WAIT_CYCLES(1)) dut_w1 (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bus1)
  );

  always #10 clk50 = ~clk50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 8'hEE;
  endfunction

  function automatic logic ack_of(input int who);
    case (who)
      0:       return bus.vid_ack;
      1:       return bus.ldr_ack;
      2:       return bus.cpu_ack;
      default: return bus1.cpu_ack;
    endcase
  endfunction

  // SRAM model: read data follows the registered address, writes land on WE_N rising.
  always @(negedge clk50) begin
    bus.sram_dq_i  = mem_rd(bus.sram_addr);
    bus1.sram_dq_i = mem_rd(bus1.sram_addr);
  end

  always @(posedge bus.sram_we_n) begin
    if (!reset && bus.sram_dq_oe) mem[int'(bus.sram_addr)] = bus.sram_dq_o;
  end

  // Monitor: scoreboard pop on ack, rdata stability, WE_N pulse width and address stability.
  logic [7:0]    prev_vid, prev_ldr, prev_cpu;
  logic [AW-1:0] prev_addr;
  int            we_low_len = 0;
  always @(negedge clk50) begin : mon
    int         n_ack;
    exp_t       e;
    logic [1:0] id;
    logic [7:0] rd;
    if (reset) begin
      we_low_len = 0;
    end else begin
      n_ack = int'(bus.vid_ack) + int'(bus.ldr_ack) + int'(bus.cpu_ack);
      if (n_ack != 0) begin
        check("ack_onehot", 32'(n_ack), 32'd1);
        id = bus.vid_ack ? ID_VID : (bus.ldr_ack ? ID_LDR : ID_CPU);
        if (sb.size() == 0) begin
          check("spurious_ack", 32'(n_ack), 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_owner", 32'(id), 32'(e.who));
          rd = (e.who == ID_VID) ? bus.vid_rdata : ((e.who == ID_LDR) ? bus.ldr_rdata : bus.cpu_rdata);
          if (e.is_rd) check("rdata", 32'(rd), 32'(e.data));
        end
      end
      if (!bus.vid_ack) check("vid_rdata_hold", 32'(bus.vid_rdata), 32'(prev_vid));
      if (!bus.ldr_ack) check("ldr_rdata_hold", 32'(bus.ldr_rdata), 32'(prev_ldr));
      if (!bus.cpu_ack) check("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'(prev_cpu));
      if (!bus.sram_we_n) begin
        we_low_len++;
        check("addr_stable_we", 32'(bus.sram_addr), 32'(prev_addr));
        check("oe_during_we", 32'(bus.sram_dq_oe), 32'd1);
      end else if (we_low_len != 0) begin
        check("we_low_len", 32'(we_low_len), 32'(W));
        we_low_len = 0;
      end
    end
    prev_vid  = bus.vid_rdata;
    prev_ldr  = bus.ldr_rdata;
    prev_cpu  = bus.cpu_rdata;
    prev_addr = bus.sram_addr;
  end

  task automatic wait_ack(input string tag, input int who, input int want_cyc);
    int cyc = 0;
    do begin
      @(negedge clk50);
      cyc++;
    end while (!ack_of(who) && cyc < 20);
    check({tag, "_ack"}, 32'(ack_of(who)), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'(want_cyc));
  endtask

  // Single CPU transaction on an idle bus, checking pin shape cycle by cycle.
  task automatic cpu_trace(input string tag, input logic we, input logic [AW-1:0] a,
                           input logic [7:0] d, input logic [5:1] x_we_n, input logic [5:1] x_oe);
    logic [5:1] x_ack;
    logic [5:1] x_busy;
    x_ack  = 5'b01000;
    x_busy = 5'b01111;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_req   = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk50);
      if (bus.cpu_ack) bus.cpu_req = 1'b0;
      check($sformatf("%s_we_n_c%0d", tag, c), 32'(bus.sram_we_n), 32'(x_we_n[c]));
      check($sformatf("%s_oe_c%0d", tag, c), 32'(bus.sram_dq_oe), 32'(x_oe[c]));
      check($sformatf("%s_addr_c%0d", tag, c), 32'(bus.sram_addr), 32'(a));
      check($sformatf("%s_ack_c%0d", tag, c), 32'(bus.cpu_ack), 32'(x_ack[c]));
      check($sformatf("%s_busy_c%0d", tag, c), 32'(bus.busy), 32'(x_busy[c]));
    end
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    {bus.vid_req, bus.ldr_req, bus.ldr_we, bus.cpu_req, bus.cpu_we} = 5'b00000;
    bus.vid_addr = '0; bus.ldr_addr = '0; bus.cpu_addr = '0;
    bus.ldr_wdata = 8'h00; bus.cpu_wdata = 8'h00;
    {bus1.vid_req, bus1.ldr_req, bus1.ldr_we, bus1.cpu_req, bus1.cpu_we} = 5'b00000;
    bus1.vid_addr = '0; bus1.ldr_addr = '0; bus1.cpu_addr = '0;
    bus1.ldr_wdata = 8'h00; bus1.cpu_wdata = 8'h00;
    mem[32'h01234] = 8'hA5;
    mem[32'h1ABCD] = 8'h77;
    mem[32'h00777] = 8'h3C;

    // Reset state
    @(negedge clk50);
    check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    check("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
    check("rst_addr", 32'(bus.sram_addr), 32'd0);
    check("rst_dq_o", 32'(bus.sram_dq_o), 32'd0);
    check("rst_acks", 32'({bus.vid_ack, bus.ldr_ack, bus.cpu_ack}), 32'd0);
    check("rst_rdata", 32'({bus.vid_rdata, bus.ldr_rdata, bus.cpu_rdata}), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk50);

    // CPU read: no drive, no WE pulse, A5 back in cycle 4
    sb.push_back('{ID_CPU, 1'b1, 8'hA5});
    cpu_trace("rd", 1'b0, 21'h01234, 8'h00, 5'b11111, 5'b00000);

    // CPU write: 1 setup, 2 WE-low, 1 hold, then bus released
    sb.push_back('{ID_CPU, 1'b0, 8'h00});
    cpu_trace("wr", 1'b1, 21'h00010, 8'h5A, 5'b11001, 5'b01111);
    check("wr_mem", 32'(mem_rd(21'h00010)), 32'h5A);

    // Video and CPU together: video first, CPU one slot later
    sb.push_back('{ID_VID, 1'b1, 8'h77});
    sb.push_back('{ID_CPU, 1'b1, 8'h5A});
    bus.vid_addr = 21'h1ABCD;
    bus.cpu_we = 1'b0; bus.cpu_addr = 21'h00010;
    bus.vid_req = 1'b1; bus.cpu_req = 1'b1;
    wait_ack("vidcpu_v", 0, 4);
    bus.vid_req = 1'b0;
    wait_ack("vidcpu_c", 2, 5);
    bus.cpu_req = 1'b0;
    @(negedge clk50);

    // Request dropped and address changed right after the grant
    sb.push_back('{ID_CPU, 1'b1, 8'hA5});
    bus.cpu_we = 1'b0; bus.cpu_addr = 21'h01234; bus.cpu_req = 1'b1;
    @(negedge clk50);
    bus.cpu_req = 1'b0; bus.cpu_addr = 21'h00777;
    wait_ack("drop", 2, 3);
    check("drop_addr", 32'(bus.sram_addr), 32'h01234);
    begin
      int extra = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk50);
        extra += int'(bus.cpu_ack);
      end
      check("drop_ack_once", 32'(extra), 32'd0);
    end

    // Loader and CPU held: CPU, LDR, CPU, five cycles apart
    sb.push_back('{ID_CPU, 1'b1, 8'hA5});
    sb.push_back('{ID_LDR, 1'b0, 8'h00});
    sb.push_back('{ID_CPU, 1'b1, 8'hA5});
    bus.ldr_we = 1'b1; bus.ldr_addr = 21'h00200; bus.ldr_wdata = 8'hC3;
    bus.cpu_we = 1'b0; bus.cpu_addr = 21'h01234;
    bus.ldr_req = 1'b1; bus.cpu_req = 1'b1;
    wait_ack("rr1_cpu", 2, 4);
    wait_ack("rr2_ldr", 1, 5);
    wait_ack("rr3_cpu", 2, 5);
    bus.ldr_req = 1'b0; bus.cpu_req = 1'b0;
    @(negedge clk50);
    check("rr_ldr_mem", 32'(mem_rd(21'h00200)), 32'hC3);

    // Reset in the middle of a write pulse; rr currently points at the loader
    sb.push_back('{ID_CPU, 1'b0, 8'h00});
    bus.cpu_we = 1'b1; bus.cpu_addr = 21'h00300; bus.cpu_wdata = 8'h55; bus.cpu_req = 1'b1;
    @(negedge clk50);
    bus.cpu_req = 1'b0;
    @(negedge clk50);
    check("rstw_pre_we_n", 32'(bus.sram_we_n), 32'd0);
    #3 reset = 1'b1;
    #1;
    check("rstw_we_n", 32'(bus.sram_we_n), 32'd1);
    check("rstw_oe", 32'(bus.sram_dq_oe), 32'd0);
    check("rstw_busy", 32'(bus.busy), 32'd0);
    check("rstw_ack", 32'(bus.cpu_ack), 32'd0);
    sb.delete();
    @(negedge clk50);
    @(negedge clk50);
    reset = 1'b0;
    @(negedge clk50);
    check("rstw_idle_busy", 32'(bus.busy), 32'd0);
    check("rstw_idle_ack", 32'(bus.cpu_ack), 32'd0);
    sb.push_back('{ID_CPU, 1'b1, 8'hA5});
    sb.push_back('{ID_LDR, 1'b1, 8'h5A});
    bus.ldr_we = 1'b0; bus.ldr_addr = 21'h00010;
    bus.cpu_we = 1'b0; bus.cpu_addr = 21'h01234;
    bus.ldr_req = 1'b1; bus.cpu_req = 1'b1;
    wait_ack("rstw_rr_cpu", 2, 4);
    bus.cpu_req = 1'b0;
    wait_ack("rstw_rr_ldr", 1, 5);
    bus.ldr_req = 1'b0;
    @(negedge clk50);

    // WAIT_CYCLES=1 instance: read acked in cycle 3
    bus1.cpu_we = 1'b0; bus1.cpu_addr = 21'h00777; bus1.cpu_req = 1'b1;
    wait_ack("w1", 3, 3);
    bus1.cpu_req = 1'b0;
    check("w1_rdata", 32'(bus1.cpu_rdata), 32'h3C);
    check("w1_we_n", 32'(bus1.sram_we_n), 32'd1);
    @(negedge clk50);
    check("w1_idle_busy", 32'(bus1.busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
